// File: rtl/traffic_light_rr.sv
// Round-robin multi-approach traffic light controller.
// Ports:
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   car_req[NUM_DIR]     : level car sensors, latched into pending
//   green/yellow/red     : per-approach lamp drivers (Moore decode)
//   active_dir           : approach owning the current phase
//   phase                : 0 GREEN, 1 YELLOW, 2 ALL_RED
//   pending[NUM_DIR]     : latched request vector
module traffic_light_rr #(
    parameter int NUM_DIR      = 4,
    parameter int DIR_W        = 2,
    parameter int TIMER_W      = 8,
    parameter int MIN_GREEN    = 4,
    parameter int MAX_GREEN    = 10,
    parameter int YELLOW_TIME  = 2,
    parameter int ALL_RED_TIME = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_DIR-1:0] car_req,
    output logic [NUM_DIR-1:0] green,
    output logic [NUM_DIR-1:0] yellow,
    output logic [NUM_DIR-1:0] red,
    output logic [DIR_W-1:0]   active_dir,
    output logic [1:0]         phase,
    output logic [NUM_DIR-1:0] pending
);

    typedef enum logic [1:0] {
        S_GREEN   = 2'd0,
        S_YELLOW  = 2'd1,
        S_ALL_RED = 2'd2
    } state_t;

    localparam logic [TIMER_W-1:0] T_MIN = TIMER_W'(MIN_GREEN - 1);
    localparam logic [TIMER_W-1:0] T_MAX = TIMER_W'(MAX_GREEN - 1);
    localparam logic [TIMER_W-1:0] T_YEL = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] T_AR  = TIMER_W'(ALL_RED_TIME - 1);
    localparam logic [TIMER_W-1:0] T_SAT = '1;
    localparam logic [NUM_DIR-1:0] ONE   = NUM_DIR'(1);

    state_t             state;
    logic [DIR_W-1:0]   cur;
    logic [DIR_W-1:0]   nxt;
    logic [TIMER_W-1:0] timer;

    logic [NUM_DIR-1:0] cur_oh;
    logic [NUM_DIR-1:0] nxt_oh;
    logic [NUM_DIR-1:0] set_mask;
    logic [NUM_DIR-1:0] clr_mask;
    logic               others;
    logic               req_cur;
    logic               go_yellow;
    logic               ar_done;
    logic [DIR_W-1:0]   scan_idx;
    logic               found;
    int                 j;

    assign cur_oh  = ONE << cur;
    assign nxt_oh  = ONE << nxt;
    assign others  = |(pending & ~cur_oh);
    assign req_cur = |(car_req & cur_oh);

    // Leave green only once the minimum has elapsed and someone else waits;
    // a still-occupied approach keeps green until the maximum.
    assign go_yellow = (timer >= T_MIN) && others &&
                       (!req_cur || timer >= T_MAX);

    assign ar_done = (state == S_ALL_RED) && (timer == T_AR);

    // The approach being served cannot re-latch its own request.
    assign set_mask = car_req & ~((state == S_GREEN) ? cur_oh : '0);
    assign clr_mask = ar_done ? nxt_oh : '0;

    // First pending approach after cur, wrapping at NUM_DIR.
    always_comb begin
        scan_idx = cur;
        found    = 1'b0;
        j        = 0;
        for (int k = 1; k < NUM_DIR; k++) begin
            j = int'(cur) + k;
            if (j >= NUM_DIR) j = j - NUM_DIR;
            if (!found && pending[j]) begin
                found    = 1'b1;
                scan_idx = DIR_W'(j);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_GREEN;
            cur     <= '0;
            nxt     <= '0;
            timer   <= '0;
            pending <= '0;
        end else begin
            // Clear wins over a simultaneous set.
            pending <= (pending | set_mask) & ~clr_mask;
            case (state)
                S_GREEN: begin
                    if (go_yellow) begin
                        state <= S_YELLOW;
                        nxt   <= scan_idx;
                        timer <= '0;
                    end else if (timer != T_SAT) begin
                        timer <= timer + 1'b1;
                    end
                end
                S_YELLOW: begin
                    if (timer == T_YEL) begin
                        state <= S_ALL_RED;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_ALL_RED: begin
                    if (timer == T_AR) begin
                        state <= S_GREEN;
                        cur   <= nxt;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= S_GREEN;
                    timer <= '0;
                end
            endcase
        end
    end

    always_comb begin
        green  = '0;
        yellow = '0;
        case (state)
            S_GREEN:  green  = cur_oh;
            S_YELLOW: yellow = cur_oh;
            default:  ;
        endcase
    end

    assign red        = ~(green | yellow);
    assign active_dir = cur;
    assign phase      = state;

endmodule

// File: doc/traffic_light_rr.md
# traffic_light_rr

Parametrised multi-approach traffic light controller, the next generation of the two-way NS/EW controller. It serves `NUM_DIR` approaches in round-robin order. Each approach has a three-aspect signal (green/yellow/red), and the controller sequences minimum-green, yellow and all-red clearance intervals. It latches car requests so short sensor pulses are never lost, and enforces a maximum green when other approaches are waiting. It sits between the per-approach car sensors and the lamp drivers, and all transitions occur on the rising edge of `clock`.

## Interface
- `NUM_DIR`, default 4: number of approaches; legal range 2..16.
- `DIR_W`, default 2: index width; must satisfy 2^DIR_W >= NUM_DIR.
- `TIMER_W`, default 8: phase timer width; every time parameter must be <= 2^TIMER_W - 1.
- `MIN_GREEN`, default 4: minimum green length in cycles; must be >= 1.
- `MAX_GREEN`, default 10: green length in cycles after which a waiting approach preempts a still-occupied approach; must be >= MIN_GREEN.
- `YELLOW_TIME`, default 2: yellow length in cycles; must be >= 1.
- `ALL_RED_TIME`, default 1: all-red clearance length in cycles; must be >= 1.

Ports (name, direction, width, meaning):
- `clock` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `car_req` input NUM_DIR: level car sensor per approach.
- `green` output NUM_DIR: green lamp, one-hot or zero.
- `yellow` output NUM_DIR: yellow lamp, one-hot or zero.
- `red` output NUM_DIR: red lamp.
- `active_dir` output DIR_W: approach currently owning the phase.
- `phase` output 2: phase code, 0 = GREEN, 1 = YELLOW, 2 = ALL_RED; 3 is never driven.
- `pending` output NUM_DIR: latched request vector.

## Operation
- The controller has three states: GREEN, YELLOW and ALL_RED. Registers are `state`, `cur` (active_dir), `nxt`, `timer` and `pending`.
- `timer` is loaded to 0 on every state entry and increments each cycle. In GREEN it saturates at 2^TIMER_W - 1.
- Outputs are a Moore decode of the registered state, with no combinational path from `car_req`:
  - In GREEN, `green` = onehot(cur) and `yellow` = 0.
  - In YELLOW, `yellow` = onehot(cur) and `green` = 0.
  - In ALL_RED, `green` = `yellow` = 0.
  - `red` = ~(green | yellow) in every state.
- The request latch updates each edge: pending[i] <= (pending[i] | car_req[i]) & ~clr[i].
  - Setting is inhibited for i == cur while in GREEN, because that approach is being served.
  - clr[i] is asserted on the edge that enters GREEN for approach i. Clear wins over a simultaneous set.
- Define others = |(pending & ~onehot(cur)).
- GREEN -> YELLOW occurs when timer >= MIN_GREEN-1 and others, and additionally either car_req[cur] == 0 or timer >= MAX_GREEN-1.
  - When others == 0, GREEN is held indefinitely, whatever the state of car_req[cur].
- On the GREEN -> YELLOW edge, `nxt` is loaded with the first index j with pending[j] = 1, scanning cur+1, cur+2, ... modulo NUM_DIR and excluding cur.
  - `nxt` is frozen for the rest of the cycle sequence; requests arriving later wait for the next round.
- YELLOW -> ALL_RED occurs when timer == YELLOW_TIME-1.
- ALL_RED -> GREEN occurs when timer == ALL_RED_TIME-1. On that edge: cur <= nxt, pending[nxt] is cleared, and timer <= 0.
- The index arithmetic wraps at NUM_DIR, not at 2^DIR_W. Indices >= NUM_DIR are never produced.

## Timing
- Reset values, taking effect on the edge where `reset` = 1:
  - state = GREEN, cur = 0, nxt = 0, timer = 0, pending = 0.
  - Resulting outputs: green = onehot(0), yellow = 0, red = ~onehot(0), phase = 0, active_dir = 0.
- Reset applied in any state, including mid-YELLOW or mid-ALL_RED, overrides everything. No partial sequence is completed.
- A car_req pulse in cycle k is visible in `pending` from cycle k+1. The earliest it can influence a transition decision is cycle k+1.
- Green lasts at least MIN_GREEN cycles and at most MAX_GREEN cycles while others == 1.
- Yellow lasts exactly YELLOW_TIME cycles and all-red lasts exactly ALL_RED_TIME cycles.
- At most one approach is non-red in any cycle. Green-to-green on different approaches always passes through YELLOW and then ALL_RED.
- A single pending approach is served within at most MAX_GREEN + YELLOW_TIME + ALL_RED_TIME cycles per approach ahead of it in round-robin order.

## Test plan
All scenarios use the default parameters.
- **Reset with no requests:** assert reset, then release it with car_req = 0 for 50 cycles. Required: green = 4'b0001, red = 4'b1110 and phase = 0 in every cycle, with no transitions.
- **Single pulse on approach 2:** pulse car_req[2] for 1 cycle immediately after reset release. Required sequence: green[0] for exactly 4 cycles, then yellow[0] for 2 cycles, then red = 4'b1111 for 1 cycle, then green[2] with pending = 0.
- **Round-robin order:** while approach 0 is green, assert car_req[3] and car_req[1] in the same cycle. Required: approach 1 is served first, then approach 3, with the full yellow and all-red sequence between them.
- **Maximum green:** hold car_req[0] = 1 throughout and pulse car_req[1]. Required: green[0] lasts exactly 10 cycles, then the sequence proceeds to approach 1.
- **Simultaneous set and clear:** assert car_req[2] on the ALL_RED -> GREEN edge for nxt = 2. Required: pending[2] = 0 after that edge.
- **Reset mid-yellow:** assert reset during the second yellow cycle of approach 1. Required on the next cycle: phase = 0, green = 4'b0001, yellow = 0 and pending = 0.
